// File: rtl/spi_tx_feeder.sv
// Paced FIFO feeder for a 16-bit SPI output shifter: one writeSPI pulse per WORD_CYCLES clocks at most.
// Optional SPI_TX_FLUSH_EN adds a synchronous 'flush' input that empties the FIFO.
module spi_tx_feeder #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int WORD_CYCLES = 16
) (
  input  logic          clock,
  input  logic          reset,
`ifdef SPI_TX_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [15:0]   wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [15:0]   data,
  output logic          writeSPI
);

  localparam int CW = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] PACE_LOAD  = CW'(WORD_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PACE = 1'b1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [0:0]    state;
  logic [CW-1:0] pace_cnt;

  logic flush_i;
  logic issue;
  logic push;
  logic drop;

`ifdef SPI_TX_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);

  // A pop is only ever the FSM issuing a pulse; a flush suppresses it so nothing stale escapes.
  assign issue = !empty && !flush_i && ((state == IDLE) || (pace_cnt == '0));
  assign push  = wr_en && !flush_i && (!full || issue);
  assign drop  = wr_en && !flush_i && full && !issue;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // pace_cnt keeps running through a flush so the next word still honours the spacing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pace_cnt <= '0;
      data     <= '0;
      writeSPI <= 1'b0;
    end else if (issue) begin
      state    <= PACE;
      pace_cnt <= PACE_LOAD;
      data     <= mem[rd_ptr];
      writeSPI <= 1'b1;
    end else begin
      writeSPI <= 1'b0;
      if (state == PACE) begin
        if (pace_cnt == '0) state <= IDLE;
        else                pace_cnt <= pace_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed self-checking bench for spi_tx_feeder; records every writeSPI pulse with its cycle number.
module tb_spi_tx_feeder;

  logic        clock = 1'b0;
  logic        reset;
`ifdef SPI_TX_FLUSH_EN
  logic        flush;
`endif
  logic [15:0] wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;
  logic        ovf_clr;
  logic [15:0] data;
  logic        writeSPI;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dbl      = 0;
  logic prev_w = 1'b0;
  int          pcyc[$];
  logic [15:0] pdat[$];

  spi_tx_feeder #(.DEPTH(8), .AW(3), .WORD_CYCLES(16)) dut (
    .clock    (clock),
    .reset    (reset),
`ifdef SPI_TX_FLUSH_EN
    .flush    (flush),
`endif
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .data     (data),
    .writeSPI (writeSPI)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (writeSPI) begin
      pcyc.push_back(cyc);
      pdat.push_back(data);
      if (prev_w) dbl++;
    end
    prev_w = writeSPI;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic clear_log();
    pcyc.delete();
    pdat.delete();
  endtask

  initial begin
    int c;
    int t;
    logic [15:0] exp_seq [10];

    reset   = 1'b1;
    wr_data = '0;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
`ifdef SPI_TX_FLUSH_EN
    flush   = 1'b0;
`endif
    #1;
    check_eq("rst_level",    32'(level),    0);
    check_eq("rst_empty",    32'(empty),    1);
    check_eq("rst_full",     32'(full),     0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_data",     32'(data),     0);
    check_eq("rst_wspi",     32'(writeSPI), 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // single word latency
    clear_log();
    c = cyc;
    write_word(16'hA55A);
    check_eq("t1_c1_wspi", 32'(writeSPI), 0);
    tick();
    check_eq("t1_c2_wspi", 32'(writeSPI), 1);
    check_eq("t1_c2_data", 32'(data), 32'hA55A);
    tick();
    check_eq("t1_c3_wspi",  32'(writeSPI), 0);
    check_eq("t1_c3_empty", 32'(empty), 1);
    check_eq("t1_c3_data",  32'(data), 32'hA55A);
    wait_until(c + 25);
    check_eq("t1_npulse", 32'(pcyc.size()), 1);

    // burst of four, then one more after the FSM idles
    clear_log();
    c = cyc;
    for (int i = 1; i <= 4; i++) write_word(16'(i));
    wait_until(c + 70);
    write_word(16'h0005);
    wait_until(c + 76);
    check_eq("t2_npulse", 32'(pcyc.size()), 5);
    if (pcyc.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("t2_cyc%0d", i),  32'(pcyc[i] - c), 32'(2 + 16 * i));
        check_eq($sformatf("t2_data%0d", i), 32'(pdat[i]), 32'(i + 1));
      end
      check_eq("t2_idle_latency", 32'(pcyc[4] - c), 72);
    end

    // late second word must still wait for the full spacing
    wait_until(c + 100);
    clear_log();
    c = cyc;
    t = c + 2;
    write_word(16'h1111);
    wait_until(t + 5);
    write_word(16'h2222);
    wait_until(t + 25);
    check_eq("t5_npulse", 32'(pcyc.size()), 2);
    if (pcyc.size() == 2) begin
      check_eq("t5_first",   32'(pcyc[0] - t), 0);
      check_eq("t5_spacing", 32'(pcyc[1] - pcyc[0]), 16);
      check_eq("t5_data",    32'(pdat[1]), 32'h2222);
    end

    // fill to full during PACE, drop the ninth, then push on the pop cycle
    wait_until(t + 40);
    clear_log();
    c = cyc;
    t = c + 2;
    write_word(16'h0100);
    wait_until(t + 1);
    for (int i = 1; i <= 9; i++) write_word(16'(16'h0100 + i));
    check_eq("t3_level",    32'(level), 8);
    check_eq("t3_full",     32'(full), 1);
    check_eq("t3_overflow", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("t3_ovf_clr", 32'(overflow), 0);
    wait_until(t + 15);
    write_word(16'h01AA);
    check_eq("t4_level",    32'(level), 8);
    check_eq("t4_overflow", 32'(overflow), 0);
    check_eq("t4_wspi",     32'(writeSPI), 1);
    check_eq("t4_data",     32'(data), 32'h0101);
    wait_until(t + 170);
    exp_seq[0] = 16'h0100;
    for (int i = 1; i <= 8; i++) exp_seq[i] = 16'(16'h0100 + i);
    exp_seq[9] = 16'h01AA;
    check_eq("t34_npulse", 32'(pcyc.size()), 10);
    if (pcyc.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check_eq($sformatf("t34_data%0d", i), 32'(pdat[i]), 32'(exp_seq[i]));
        check_eq($sformatf("t34_cyc%0d", i),  32'(pcyc[i] - t), 32'(16 * i));
      end
    end
    check_eq("t34_empty", 32'(empty), 1);

    // reset in the middle of PACE discards queued words
    c = cyc;
    write_word(16'h3333);
    write_word(16'h4444);
    wait_until(c + 5);
    reset = 1'b1;
    #1;
    check_eq("rstmid_level", 32'(level), 0);
    check_eq("rstmid_empty", 32'(empty), 1);
    check_eq("rstmid_wspi",  32'(writeSPI), 0);
    tick();
    reset = 1'b0;
    clear_log();
    repeat (40) tick();
    check_eq("rstmid_npulse", 32'(pcyc.size()), 0);

`ifdef SPI_TX_FLUSH_EN
    clear_log();
    c = cyc;
    t = c + 2;
    write_word(16'h5001);
    write_word(16'h5002);
    write_word(16'h5003);
    wait_until(t + 4);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 16'hBEEF;
    tick();
    flush   = 1'b0;
    wr_en   = 1'b0;
    check_eq("t6_level",    32'(level), 0);
    check_eq("t6_empty",    32'(empty), 1);
    check_eq("t6_overflow", 32'(overflow), 0);
    wait_until(t + 10);
    write_word(16'h6666);
    wait_until(t + 40);
    check_eq("t6_npulse", 32'(pcyc.size()), 2);
    if (pcyc.size() == 2) begin
      check_eq("t6_spacing", 32'(pcyc[1] - pcyc[0]), 16);
      check_eq("t6_data",    32'(pdat[1]), 32'h6666);
    end
`endif

    check_eq("no_double_pulse", 32'(dbl), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
